// File: rtl/poly_result_fifo.sv
// rtl/poly_result_fifo.sv - first-word-fall-through result FIFO for the polynomial evaluator
//
// Purpose: captures each signed evaluator result on its one-cycle in_valid
// pulse, buffers it in a DEPTH-entry FIFO and hands it to the consumer over a
// ready/valid handshake. Results arriving with no room are discarded and
// counted. Optional feature macro: RESULT_ACC_EN (adds a saturating running
// sum of every accepted result).
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   in_valid    evaluator result strobe (one cycle)
//   in_data     evaluator result y (signed)
//   out_ready   consumer accepts out_data this cycle
//   out_valid   FIFO holds at least one entry
//   out_data    head entry, 0 when empty
//   full        count == DEPTH (holds off the evaluator enable)
//   empty       count == 0
//   count       number of stored entries
//   overflow    sticky, set on first dropped result
//   drop_count  saturating count of dropped results
//   acc_clr     (RESULT_ACC_EN) clear accumulator, wins over a same-cycle push
//   acc         (RESULT_ACC_EN) saturating signed sum of accepted results

module poly_result_fifo #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 16,
  parameter int DROP_W = 8
) (
  input  logic                       clock,
  input  logic                       reset,
`ifdef RESULT_ACC_EN
  input  logic                       acc_clr,
  output logic signed [WIDTH+8-1:0]  acc,
`endif
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic push, pop, drop;

  // Flags decode registered state only, so they never depend on this
  // cycle's handshake inputs.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // A full FIFO can still accept when the head leaves in the same cycle.
  assign pop  = out_valid & out_ready;
  assign push = in_valid & (~full | pop);
  assign drop = in_valid & full & ~pop;

  assign out_valid  = ~empty;
  // Forcing 0 while empty keeps stale memory contents from ever showing.
  assign out_data   = empty ? '0 : mem_q[rd_ptr_q];
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage is not reset; its contents are masked by out_data while empty.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

`ifdef RESULT_ACC_EN
  localparam int AW = WIDTH + 8;
  localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  logic [AW-1:0] acc_q, acc_d;
  logic [AW:0]   acc_sum;

  // One guard bit: a mismatch between the top two sum bits means the
  // signed result left the AW-bit range, and the guard bit gives the sign.
  always_comb begin
    acc_sum = {acc_q[AW-1], acc_q} + {{(AW+1-WIDTH){in_data[WIDTH-1]}}, in_data};
    acc_d   = acc_q;
    if (acc_clr) begin
      acc_d = '0;
    end else if (push) begin
      if (acc_sum[AW] != acc_sum[AW-1]) acc_d = acc_sum[AW] ? ACC_MIN : ACC_MAX;
      else                              acc_d = acc_sum[AW-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;
`endif

endmodule

// File: tb/tb_poly_result_fifo.sv
// tb/tb_poly_result_fifo.sv - scoreboard testbench for poly_result_fifo
module tb_poly_result_fifo;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [15:0]       in_data;
  logic              out_ready;
  logic              out_valid;
  logic [15:0]       out_data;
  logic              full;
  logic              empty;
  logic [2:0]        count;
  logic              overflow;
  logic [7:0]        drop_count;
`ifdef RESULT_ACC_EN
  logic              acc_clr;
  logic signed [23:0] acc;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  poly_result_fifo #(.DEPTH(4), .WIDTH(16), .DROP_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
`ifdef RESULT_ACC_EN
    .acc_clr    (acc_clr),
    .acc        (acc),
`endif
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one value for one cycle; stored values join the scoreboard.
  task automatic push_one(input int v, input bit stored);
    in_valid = 1'b1;
    in_data  = 16'(v);
    if (stored) exp_q.push_back(v);
    tick();
    in_valid = 1'b0;
  endtask

  // Monitor: every accepted output is compared against the scoreboard head.
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %0d expected none", $signed(out_data));
      end else begin
        check("out_data", longint'($signed(out_data)), longint'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef RESULT_ACC_EN
    acc_clr   = 1'b0;
`endif
    tick(); tick();
    reset = 1'b1;
    tick();
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_valid", out_valid, 0);
    check("rst_drops", drop_count, 0);

    // out_ready while empty does nothing
    out_ready = 1'b1;
    tick();
    check("idle_ready_count", count, 0);
    out_ready = 1'b0;

    // Test 1: async reset with 2 entries held and out_ready high
    push_one(1, 1);
    push_one(2, 1);
    check("t1_pre_count", count, 2);
    out_ready = 1'b1;
    reset     = 1'b0;
    #1;
    check("t1_count", count, 0);
    check("t1_empty", empty, 1);
    check("t1_valid", out_valid, 0);
    check("t1_data", out_data, 0);
    check("t1_overflow", overflow, 0);
    exp_q.delete();
    tick();
    out_ready = 1'b0;
    reset     = 1'b1;
    tick();

    // Test 2: three pushes, then drain on consecutive cycles
    push_one(100, 1);
    push_one(-5, 1);
    push_one(32767, 1);
    check("t2_count", count, 3);
    check("t2_head", out_data, 100);
    out_ready = 1'b1;
    tick(); tick(); tick();
    check("t2_empty", empty, 1);
    check("t2_q_drained", exp_q.size(), 0);
    out_ready = 1'b0;

    // Test 3: overflow while full, contents untouched
    push_one(11, 1);
    push_one(22, 1);
    push_one(33, 1);
    push_one(44, 1);
    check("t3_full", full, 1);
    push_one(7, 0);
    check("t3_count", count, 4);
    check("t3_overflow", overflow, 1);
    check("t3_drops", drop_count, 1);
    out_ready = 1'b1;
    tick(); tick(); tick(); tick();
    check("t3_empty", empty, 1);
    check("t3_q_drained", exp_q.size(), 0);
    check("t3_overflow_sticky", overflow, 1);
    out_ready = 1'b0;

    // Test 4: push and pop together while full
    push_one(51, 1);
    push_one(52, 1);
    push_one(53, 1);
    push_one(54, 1);
    out_ready = 1'b1;
    push_one(9, 1);
    out_ready = 1'b0;
    check("t4_count", count, 4);
    check("t4_drops", drop_count, 1);
    out_ready = 1'b1;
    tick(); tick(); tick(); tick();
    check("t4_empty", empty, 1);
    check("t4_q_drained", exp_q.size(), 0);
    out_ready = 1'b0;

    // Test 5: pointer wrap with continuous push/pop
    push_one(0, 1);
    out_ready = 1'b1;
    for (int v = 1; v <= 10; v++) begin
      push_one(v, 1);
      check("t5_count", count, 1);
    end
    tick();
    check("t5_empty", empty, 1);
    check("t5_q_drained", exp_q.size(), 0);
    out_ready = 1'b0;

`ifdef RESULT_ACC_EN
    // Test 6: saturating accumulator
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    check("t6_acc_clr", acc, 0);
    out_ready = 1'b1;
    push_one(30000, 1);
    push_one(-1000, 1);
    check("t6_acc_sum", acc, 29000);
    for (int i = 0; i < 300; i++) push_one(32767, 1);
    check("t6_acc_sat", acc, 8388607);
    acc_clr = 1'b1;
    push_one(5, 1);
    acc_clr = 1'b0;
    check("t6_acc_clr_push", acc, 0);
    tick(); tick();
    check("t6_q_drained", exp_q.size(), 0);
    out_ready = 1'b0;
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/poly_result_fifo.md
Name: poly_result_fifo

Overview:
- Downstream stage of the polynomial evaluator's control/datapath pair.
- Captures each 16-bit signed result `y` on the evaluator's one-cycle `valid` pulse.
- Buffers results in a small first-word-fall-through FIFO and presents them to the consumer over a ready/valid handshake.
- The evaluator cannot be stalled mid-computation, so the FIFO exports `full` to gate the evaluator's `enable`. It also counts any result that arrives while there is no room.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- WIDTH, 16, result width in bits; signed two's complement.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  one-cycle pulse from the evaluator; `in_data` is valid this cycle.
- in_data  input  WIDTH  signed result `y` from the evaluator.
- out_ready  input  1  consumer can accept `out_data` this cycle.
- out_valid  output  1  FIFO holds at least one entry.
- out_data  output  WIDTH  head entry (signed); 0 when empty.
- full  output  1  count == DEPTH; used upstream to hold off `enable`.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH)+1  number of stored entries.
- overflow  output  1  sticky; set on the first dropped result.
- drop_count  output  DROP_W  dropped results; saturates at all-ones.

Behaviour:
- Reset (`reset` = 0, async, any time, including mid-transfer):
  - Read/write pointers, `count`, `overflow` and `drop_count` go to 0.
  - `empty` = 1, `full` = 0, `out_valid` = 0, `out_data` = 0.
  - Memory contents are not cleared and never become visible, because `out_data` is forced to 0 while empty.
- Derived events, evaluated each cycle:
  - pop = out_valid & out_ready.
  - push = in_valid & (!full | pop).
  - drop = in_valid & full & !pop.
- Push: write `in_data` to mem[wr_ptr]; wr_ptr increments modulo DEPTH (natural wrap, pointer width $clog2(DEPTH)).
- Pop: rd_ptr increments modulo DEPTH.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push & pop, or on neither.
- Output path (first-word-fall-through):
  - `out_data` = mem[rd_ptr] combinationally when !empty, else 0.
  - `out_valid` = !empty.
  - Push-to-`out_valid` latency from empty is 1 cycle; data never bypasses combinationally from `in_data`.
- Empty with `in_valid`: the push happens; no pop is possible in the same cycle.
- Full with `in_valid` and `out_ready`: pop and push both occur; `count` stays DEPTH; nothing is dropped; order is preserved.
- Full with `in_valid` and no pop: the result is discarded.
  - `overflow` is set and stays set until reset.
  - `drop_count` increments, holding at 2^DROP_W-1.
  - FIFO contents are unchanged.
- `out_ready` while empty has no effect.
- `full` and `empty` are registered-state decodes of `count`; they are never combinational on this cycle's `in_valid` or `out_ready`.
- Data is stored bit-exact; no sign handling is needed except in the optional accumulator.
- Control structure is two pointers plus a counter; there is no other FSM.

Optional Feature:
- Macro: RESULT_ACC_EN.
- When defined, the block adds two ports:
  - input `acc_clr` (1 bit).
  - output `acc` (signed, WIDTH+8 bits).
- `acc` behaviour:
  - Reset value is 0.
  - On each push, `acc` becomes acc + sign-extended `in_data`, saturating to the signed range of WIDTH+8.
  - `acc_clr` = 1 loads 0; it takes priority over a same-cycle push, and that push's value is not added.
  - Dropped results are never accumulated.
- When undefined, neither port exists and no accumulator logic is generated.

Test Plan:
1. Assert `reset` = 0 while the FIFO holds 2 entries and `out_ready` = 1 -> immediately `count` = 0, `empty` = 1, `out_valid` = 0, `out_data` = 0, `overflow` = 0.
2. Push 100, -5, 32767 with `out_ready` = 0 -> `count` = 3, `out_data` = 100. Then hold `out_ready` = 1 -> outputs 100, -5, 32767 on consecutive cycles, then `empty` = 1.
3. Fill 4 entries, then pulse `in_valid` with 7 while `out_ready` = 0 -> `count` stays 4, `overflow` = 1, `drop_count` = 1. Draining yields the original 4 values only.
4. Full, with `in_valid` (value 9) and `out_ready` in the same cycle -> `count` stays 4, `drop_count` unchanged, 9 emerges last.
5. Wrap-around: 10 cycles of simultaneous push/pop, values 1..10, after priming with one entry (0) -> outputs 0..9 in order, `count` stays 1.
6. With RESULT_ACC_EN: push 30000 and -1000 -> `acc` = 29000. Push 300 x 32767 -> `acc` = 8388607 (saturated). Pulse `acc_clr` with a simultaneous push -> `acc` = 0.
